// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multdiv sequencer: FSM states, adder
// operation codes and product-register shift modes.
package multdiv_pkg;

  localparam int MD_WIDTH      = 32;
  localparam int MD_MULT_ITERS = MD_WIDTH / 2;
  localparam int MD_DIV_ITERS  = MD_WIDTH;
  localparam int MD_CNT_W      = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ITER  = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ALU_NONE = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_HOLD = 2'b00,
    SH_ASR2 = 2'b01,
    SH_SHL1 = 2'b10
  } shift_e;

endpackage

// File: rtl/multdiv_ctrl_if.sv
// Control/status bundle between the multdiv sequencer (slave) and the
// processor/datapath side that feeds it (master).
interface multdiv_ctrl_if;
  import multdiv_pkg::*;

  logic       ctrl_mult;
  logic       ctrl_div;
  logic [2:0] prod_lsb;
  logic       rem_neg;
  logic       divisor_zero;
  logic       ovf_detect;

  logic       preg_en;
  logic       preg_clr;
  logic       preg_init;
  alu_op_e    alu_op;
  logic       alu_x2;
  shift_e     shift_mode;
  logic       qbit;
  logic       sign_fix;
  logic       is_div;
  logic       busy;
  logic       result_rdy;
  logic       exception;

  modport slave (
    input  ctrl_mult, ctrl_div, prod_lsb, rem_neg, divisor_zero, ovf_detect,
    output preg_en, preg_clr, preg_init, alu_op, alu_x2, shift_mode, qbit,
           sign_fix, is_div, busy, result_rdy, exception
  );

  modport master (
    output ctrl_mult, ctrl_div, prod_lsb, rem_neg, divisor_zero, ovf_detect,
    input  preg_en, preg_clr, preg_init, alu_op, alu_x2, shift_mode, qbit,
           sign_fix, is_div, busy, result_rdy, exception
  );

endinterface

// File: rtl/booth4_decode.sv
// Radix-4 Booth recoder: maps the 3-bit multiplier window (with implicit
// bit) to the adder operation and the 2*M operand select.
module booth4_decode
  import multdiv_pkg::*;
(
  input  logic [2:0] win_i,
  output alu_op_e    alu_op_o,
  output logic       alu_x2_o
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; no latch can be inferred.
    alu_op_o = ALU_NONE;
    alu_x2_o = 1'b0;
    case (win_i)
      3'b001, 3'b010: alu_op_o = ALU_ADD;
      3'b011: begin
        alu_op_o = ALU_ADD;
        alu_x2_o = 1'b1;
      end
      3'b100: begin
        alu_op_o = ALU_SUB;
        alu_x2_o = 1'b1;
      end
      3'b101, 3'b110: alu_op_o = ALU_SUB;
      default: ;
    endcase
  end

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared 65-bit product/remainder register: radix-4 Booth
// multiply and restoring divide on one datapath, with abort-on-restart.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int MULT_ITERS = MD_MULT_ITERS,
  parameter int DIV_ITERS  = MD_DIV_ITERS,
  parameter int CNT_W      = MD_CNT_W
) (
  input logic          clk,
  input logic          clr_n,
  multdiv_ctrl_if.slave md_if
);

  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_ITERS - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_ITERS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             dz_q, dz_d;

  alu_op_e booth_op;
  logic    booth_x2;
  logic    last_iter;

  logic    preg_en, preg_init, alu_x2, qbit, sign_fix, busy, result_rdy, exception;
  alu_op_e alu_op;
  shift_e  shift_mode;

  booth4_decode u_booth (
    .win_i    (md_if.prod_lsb),
    .alu_op_o (booth_op),
    .alu_x2_o (booth_x2)
  );

  assign last_iter = is_div_q ? (cnt_q == DIV_LAST) : (cnt_q == MULT_LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    dz_d       = dz_q;
    preg_en    = 1'b0;
    preg_init  = 1'b0;
    alu_op     = ALU_NONE;
    alu_x2     = 1'b0;
    shift_mode = SH_HOLD;
    qbit       = 1'b0;
    sign_fix   = 1'b0;
    busy       = 1'b0;
    result_rdy = 1'b0;
    exception  = 1'b0;

    case (state_q)
      ST_LOAD: begin
        busy      = 1'b1;
        preg_en   = 1'b1;
        preg_init = 1'b1;
        cnt_d     = '0;
        state_d   = ST_ITER;
      end
      ST_ITER: begin
        busy    = 1'b1;
        preg_en = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (is_div_q) begin
          // Trial subtract every cycle; a negative result keeps the shifted value.
          shift_mode = SH_SHL1;
          alu_op     = ALU_SUB;
          qbit       = ~md_if.rem_neg;
          if (last_iter) state_d = ST_FIXUP;
        end else begin
          shift_mode = SH_ASR2;
          alu_op     = booth_op;
          alu_x2     = booth_x2;
          if (last_iter) state_d = ST_DONE;
        end
      end
      ST_FIXUP: begin
        busy     = 1'b1;
        preg_en  = 1'b1;
        sign_fix = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        result_rdy = 1'b1;
        exception  = is_div_q ? dz_q : md_if.ovf_detect;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A start pulse in any state restarts; multiply has priority over divide.
    if (md_if.ctrl_mult) begin
      state_d  = ST_LOAD;
      is_div_d = 1'b0;
      dz_d     = 1'b0;
    end else if (md_if.ctrl_div) begin
      is_div_d = 1'b1;
      dz_d     = md_if.divisor_zero;
      state_d  = md_if.divisor_zero ? ST_DONE : ST_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking updates so all flops sample pre-edge values together.
    if (!clr_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
    end
  end

  assign md_if.preg_en    = preg_en;
  assign md_if.preg_clr   = ~clr_n;
  assign md_if.preg_init  = preg_init;
  assign md_if.alu_op     = alu_op;
  assign md_if.alu_x2     = alu_x2;
  assign md_if.shift_mode = shift_mode;
  assign md_if.qbit       = qbit;
  assign md_if.sign_fix   = sign_fix;
  assign md_if.is_div     = is_div_q;
  assign md_if.busy       = busy;
  assign md_if.result_rdy = result_rdy;
  assign md_if.exception  = exception;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: a behavioural product/remainder register
// closes the loop so products and quotients can be compared to hand values.
module tb_multdiv_ctrl;
  import multdiv_pkg::*;

  logic clk;
  logic clr_n;
  multdiv_ctrl_if md_if ();

  multdiv_ctrl dut (
    .clk   (clk),
    .clr_n (clr_n),
    .md_if (md_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operands as seen by the datapath load mux.
  logic [31:0] tb_a, tb_b;
  logic        tb_div;

  // Behavioural datapath state.
  logic signed [33:0] acc, mcand;
  logic [32:0]        lo;
  logic [32:0]        rem;
  logic [31:0]        quo, dvs;
  logic               neg_q, neg_r;

  logic signed [33:0] mop, addend, msum;
  logic [63:0]        prod;
  logic [32:0]        shifted, trial;

  always_comb begin
    mop     = md_if.alu_x2 ? (mcand <<< 1) : mcand;
    addend  = (md_if.alu_op == ALU_ADD) ? mop :
              (md_if.alu_op == ALU_SUB) ? -mop : 34'sd0;
    msum    = acc + addend;
    prod    = {acc[31:0], lo[32:1]};
    shifted = {rem[31:0], quo[31]};
    trial   = shifted - {1'b0, dvs};
  end

  assign md_if.prod_lsb     = lo[2:0];
  assign md_if.rem_neg      = trial[32];
  assign md_if.ovf_detect   = !((&prod[63:31]) || !(|prod[63:31]));
  assign md_if.divisor_zero = (tb_b == 32'd0);

  always @(posedge clk) begin
    if (md_if.preg_clr) begin
      acc <= '0; lo <= '0; rem <= '0; quo <= '0;
    end else if (md_if.preg_en) begin
      if (md_if.preg_init) begin
        if (tb_div) begin
          rem   <= '0;
          quo   <= tb_a[31] ? -tb_a : tb_a;
          dvs   <= tb_b[31] ? -tb_b : tb_b;
          neg_q <= tb_a[31] ^ tb_b[31];
          neg_r <= tb_a[31];
        end else begin
          acc   <= '0;
          lo    <= {tb_b, 1'b0};
          mcand <= {{2{tb_a[31]}}, tb_a};
        end
      end else if (md_if.shift_mode == SH_ASR2) begin
        {acc, lo} <= 67'($signed({msum, lo}) >>> 2);
      end else if (md_if.shift_mode == SH_SHL1) begin
        rem <= md_if.qbit ? trial : shifted;
        quo <= {quo[30:0], md_if.qbit};
      end else if (md_if.sign_fix) begin
        if (neg_q) quo <= -quo;
        if (neg_r) rem <= -rem;
      end
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  typedef struct {
    int       lat;
    logic     exc;
    int       sh;
    int       pe;
    int       sf;
    int       rdy;
    logic     isdiv;
    int       bad_op;
    logic [12:0] post;
    logic     post_clr;
  } res_t;

  // Start at cycle 0, observe cycles 1..70. Optional divide restart at
  // cycle div_at and reset pulse at cycle rst_at (0 disables each).
  task automatic run(input bit sm, input bit sd, input logic [31:0] a, input logic [31:0] b,
                     input int div_at, input logic [31:0] a2, input logic [31:0] b2,
                     input int rst_at, output res_t r);
    r.lat = 0; r.exc = 1'b0; r.sh = 0; r.pe = 0; r.sf = 0; r.rdy = 0;
    r.isdiv = 1'b0; r.bad_op = 0; r.post = '1; r.post_clr = 1'b0;
    tb_a = a; tb_b = b; tb_div = sd && !sm;
    @(negedge clk);
    md_if.ctrl_mult = sm;
    md_if.ctrl_div  = sd;
    @(negedge clk);
    md_if.ctrl_mult = 1'b0;
    md_if.ctrl_div  = 1'b0;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      if (md_if.result_rdy) begin
        r.rdy++;
        if (r.lat == 0) begin
          r.lat   = cyc;
          r.exc   = md_if.exception;
          r.isdiv = md_if.is_div;
        end
      end
      if (md_if.shift_mode != SH_HOLD) r.sh++;
      if (md_if.shift_mode == SH_SHL1 && md_if.alu_op != ALU_SUB) r.bad_op++;
      if (md_if.preg_en) r.pe++;
      if (md_if.sign_fix && r.sf == 0) r.sf = cyc;
      if (rst_at != 0 && cyc == rst_at + 1) begin
        r.post = {md_if.busy, md_if.preg_en, md_if.preg_init, md_if.alu_op, md_if.alu_x2,
                  md_if.shift_mode, md_if.qbit, md_if.sign_fix, md_if.is_div,
                  md_if.result_rdy, md_if.exception};
        r.post_clr = md_if.preg_clr;
        clr_n = 1'b1;
      end
      md_if.ctrl_div = (cyc == div_at);
      if (cyc == div_at) begin
        tb_a = a2; tb_b = b2; tb_div = 1'b1;
      end
      if (cyc == rst_at) clr_n = 1'b0;
      @(negedge clk);
    end
    md_if.ctrl_div = 1'b0;
  endtask

  typedef struct {
    bit          is_div;
    logic [31:0] a, b;
    bit          chk_res;
    logic [63:0] res;
    int          lat;
    bit          exc;
    int          sh, pe, sf;
  } vec_t;

  vec_t  vecs[11];
  res_t  r;
  logic [63:0] got;

  initial begin
    vecs[0]  = '{1'b0, 32'd7,          32'd6,          1'b1, 64'd42,                 18, 1'b0, 16, 17, 0};
    vecs[1]  = '{1'b0, 32'h7FFF_FFFF,  32'd2,          1'b1, 64'h0000_0000_FFFF_FFFE, 18, 1'b1, 16, 17, 0};
    vecs[2]  = '{1'b0, 32'hFFFF_FFFD,  32'd5,          1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 18, 1'b0, 16, 17, 0};
    vecs[3]  = '{1'b0, 32'h1234_5678,  32'hFFFF_FFFE,  1'b1, 64'hFFFF_FFFF_DB97_5310, 18, 1'b0, 16, 17, 0};
    vecs[4]  = '{1'b0, 32'hFFFF_FFF8,  32'hFFFF_FFF8,  1'b1, 64'd64,                 18, 1'b0, 16, 17, 0};
    vecs[5]  = '{1'b0, 32'h8000_0000,  32'h8000_0000,  1'b1, 64'h4000_0000_0000_0000, 18, 1'b1, 16, 17, 0};
    vecs[6]  = '{1'b1, 32'hFFFF_FFEC,  32'd3,          1'b1, 64'hFFFF_FFFF_FFFF_FFFA, 35, 1'b0, 32, 34, 34};
    vecs[7]  = '{1'b1, 32'd100,        32'd7,          1'b1, 64'd14,                 35, 1'b0, 32, 34, 34};
    vecs[8]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 35, 1'b0, 32, 34, 34};
    vecs[9]  = '{1'b1, 32'd10,         32'd0,          1'b0, 64'd0,                  1,  1'b1, 0,  0,  0};
    vecs[10] = '{1'b1, 32'h8000_0000,  32'd1,          1'b1, 64'hFFFF_FFFF_8000_0000, 35, 1'b0, 32, 34, 34};

    clr_n = 1'b0;
    md_if.ctrl_mult = 1'b0;
    md_if.ctrl_div  = 1'b0;
    tb_a = '0; tb_b = 32'd1; tb_div = 1'b0;
    repeat (2) @(negedge clk);
    check("rst preg_clr",   64'(md_if.preg_clr),  64'd1);
    check("rst busy",       64'(md_if.busy),       64'd0);
    check("rst result_rdy", 64'(md_if.result_rdy), 64'd0);
    check("rst preg_en",    64'(md_if.preg_en),    64'd0);
    check("rst exception",  64'(md_if.exception),  64'd0);
    check("rst is_div",     64'(md_if.is_div),     64'd0);
    clr_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run(!vecs[i].is_div, vecs[i].is_div, vecs[i].a, vecs[i].b, 0, '0, '0, 0, r);
      got = vecs[i].is_div ? {{32{quo[31]}}, quo} : prod;
      check($sformatf("v%0d latency", i),    64'(r.lat),    64'(vecs[i].lat));
      check($sformatf("v%0d exception", i),  64'(r.exc),    64'(vecs[i].exc));
      check($sformatf("v%0d rdy pulses", i), 64'(r.rdy),    64'd1);
      check($sformatf("v%0d is_div", i),     64'(r.isdiv),  64'(vecs[i].is_div));
      check($sformatf("v%0d shift cyc", i),  64'(r.sh),     64'(vecs[i].sh));
      check($sformatf("v%0d preg_en cyc", i), 64'(r.pe),    64'(vecs[i].pe));
      check($sformatf("v%0d sign_fix cyc", i), 64'(r.sf),   64'(vecs[i].sf));
      check($sformatf("v%0d div alu_op", i), 64'(r.bad_op), 64'd0);
      if (vecs[i].chk_res) check($sformatf("v%0d result", i), got, vecs[i].res);
    end

    // Both starts together: multiply wins.
    run(1'b1, 1'b1, 32'd7, 32'd6, 0, '0, '0, 0, r);
    check("both latency", 64'(r.lat),   64'd18);
    check("both is_div",  64'(r.isdiv), 64'd0);
    check("both product", prod,         64'd42);

    // Divide restart at cycle 9 aborts the multiply.
    run(1'b1, 1'b0, 32'd7, 32'd6, 9, 32'd100, 32'd7, 0, r);
    check("abort latency",  64'(r.lat),   64'd44);
    check("abort rdy",      64'(r.rdy),   64'd1);
    check("abort is_div",   64'(r.isdiv), 64'd1);
    check("abort sign_fix", 64'(r.sf),    64'd43);
    check("abort quotient", {{32{quo[31]}}, quo}, 64'd14);

    // Reset at cycle 10 of a divide.
    run(1'b0, 1'b1, 32'hFFFF_FFEC, 32'd3, 0, '0, '0, 10, r);
    check("midrst outputs",  64'(r.post),     64'd0);
    check("midrst preg_clr", 64'(r.post_clr), 64'd1);
    check("midrst rdy",      64'(r.rdy),      64'd0);
    check("midrst busy",     64'(md_if.busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
